// File: rtl/mem_router_if.sv
// Core-side request bus plus the shared slave bus of the memory router.
// The router attaches through the slave modport; the core/slave side uses master.
interface mem_router_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  logic        rom_valid;
  logic        ram_valid;
  logic        io_valid;
  logic        rom_ready;
  logic        ram_ready;
  logic        io_ready;
  logic [31:0] rom_rdata;
  logic [31:0] ram_rdata;
  logic [31:0] io_rdata;

  logic        bus_fault;
  logic [31:0] err_addr;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  rom_ready, ram_ready, io_ready, rom_rdata, ram_rdata, io_rdata,
    output mem_ready, mem_rdata, s_addr, s_wdata, s_wstrb,
    output rom_valid, ram_valid, io_valid, bus_fault, err_addr
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output rom_ready, ram_ready, io_ready, rom_rdata, ram_rdata, io_rdata,
    input  mem_ready, mem_rdata, s_addr, s_wdata, s_wstrb,
    input  rom_valid, ram_valid, io_valid, bus_fault, err_addr
  );
endinterface

// File: rtl/mem_router.sv
// Routes single core requests to ROM/RAM/IO slaves with a wait timeout and a
// sticky bus-fault record of the first failing address.
module mem_router #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] ROM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter logic [31:0] RAM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] IO_BASE  = 32'h8000_0000,
  parameter logic [31:0] IO_MASK  = 32'hFFFF_F000,
  parameter int          TIMEOUT  = 16
) (
  input logic         clk,
  input logic         rst,
  mem_router_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2, ST_ERR = 2'd3} state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_ROM = 2'd1, SEL_RAM = 2'd2, SEL_IO = 2'd3} sel_t;

  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [31:0] FAULT_DAT = 32'hDEAD_BEEF;

  state_t      state_q, state_d;
  sel_t        sel_q, sel_d, req_sel_s;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic        rom_valid_q, ram_valid_q, io_valid_q;
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_fault_q, bus_fault_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        sel_ready_s, fault_s;
  logic [31:0] sel_rdata_s, fault_addr_s;

  // Region decode of the incoming address, ROM > RAM > IO
  always_comb begin
    if ((bus.mem_addr & ROM_MASK) == ROM_BASE) begin
      req_sel_s = SEL_ROM;
    end else if ((bus.mem_addr & RAM_MASK) == RAM_BASE) begin
      req_sel_s = SEL_RAM;
    end else if ((bus.mem_addr & IO_MASK) == IO_BASE) begin
      req_sel_s = SEL_IO;
    end else begin
      req_sel_s = SEL_NONE;
    end
  end

  // Only the selected slave's ready/rdata are ever looked at
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rdata_s = 32'h0000_0000;
    case (sel_q)
      SEL_ROM: begin sel_ready_s = bus.rom_ready; sel_rdata_s = bus.rom_rdata; end
      SEL_RAM: begin sel_ready_s = bus.ram_ready; sel_rdata_s = bus.ram_rdata; end
      SEL_IO:  begin sel_ready_s = bus.io_ready;  sel_rdata_s = bus.io_rdata;  end
      default: begin sel_ready_s = 1'b0;          sel_rdata_s = 32'h0000_0000; end
    endcase
  end

  // Next-state logic; RESP and ERR accept a new request exactly like IDLE so
  // back-to-back transfers lose no cycle
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    mem_rdata_d  = mem_rdata_q;
    bus_fault_d  = bus_fault_q;
    err_addr_d   = err_addr_q;
    fault_s      = 1'b0;
    fault_addr_s = s_addr_q;
    case (state_q)
      ST_BUSY: begin
        if (sel_ready_s) begin
          state_d = ST_RESP;
          if (s_wstrb_q == 4'b0000) begin
            mem_rdata_d = sel_rdata_s;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
          fault_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_IDLE, ST_RESP, ST_ERR: begin
        if (bus.mem_valid) begin
          s_addr_d  = bus.mem_addr;
          s_wdata_d = bus.mem_wdata;
          s_wstrb_d = bus.mem_wstrb;
          sel_d     = req_sel_s;
          cnt_d     = 8'd0;
          if ((req_sel_s == SEL_NONE) || ((req_sel_s == SEL_ROM) && (bus.mem_wstrb != 4'b0000))) begin
            state_d      = ST_ERR;
            fault_s      = 1'b1;
            fault_addr_s = bus.mem_addr;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fault_s) begin
      mem_rdata_d = FAULT_DAT;
      bus_fault_d = 1'b1;
      if (!bus_fault_q) begin
        err_addr_d = fault_addr_s;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else begin
      bus_fault_d = bus_fault_q;
    end
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_NONE;
      cnt_q       <= 8'd0;
      s_addr_q    <= 32'h0000_0000;
      s_wdata_q   <= 32'h0000_0000;
      s_wstrb_q   <= 4'b0000;
      rom_valid_q <= 1'b0;
      ram_valid_q <= 1'b0;
      io_valid_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      bus_fault_q <= 1'b0;
      err_addr_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      rom_valid_q <= (state_d == ST_BUSY) && (sel_d == SEL_ROM);
      ram_valid_q <= (state_d == ST_BUSY) && (sel_d == SEL_RAM);
      io_valid_q  <= (state_d == ST_BUSY) && (sel_d == SEL_IO);
      mem_ready_q <= (state_d == ST_RESP) || (state_d == ST_ERR);
      mem_rdata_q <= mem_rdata_d;
      bus_fault_q <= bus_fault_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.s_wstrb   = s_wstrb_q;
  assign bus.rom_valid = rom_valid_q;
  assign bus.ram_valid = ram_valid_q;
  assign bus.io_valid  = io_valid_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.bus_fault = bus_fault_q;
  assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed scenario bench for mem_router; cycle n means n rising edges after
// the edge at which the request was presented.
module tb_mem_router;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_router_if bus ();

  mem_router dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL reset_mem_ready got=%b exp=0", bus.mem_ready); end
    total++; if ({bus.rom_valid, bus.ram_valid, bus.io_valid} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b exp=000", {bus.rom_valid, bus.ram_valid, bus.io_valid}); end
    total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.mem_rdata); end
    total++; if ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== 68'h0) begin bad++; $display("FAIL reset_s_bus got=%h exp=0", {bus.s_addr, bus.s_wdata, bus.s_wstrb}); end
    total++; if ({bus.bus_fault, bus.err_addr} !== 33'h0) begin bad++; $display("FAIL reset_fault got=%b/%h exp=0/0", bus.bus_fault, bus.err_addr); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram_read();
    bus.ram_rdata = 32'h1234_5678;
    bus.rom_rdata = 32'hAAAA_AAAA;
    drive_req(32'h0001_0004, 32'h0, 4'b0000);
    tick();
    bus.mem_valid = 1'b0;
    total++; if ({bus.rom_valid, bus.ram_valid, bus.io_valid} !== 3'b010) begin bad++; $display("FAIL ram_rd_c1_valids got=%b exp=010", {bus.rom_valid, bus.ram_valid, bus.io_valid}); end
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL ram_rd_c1_ready got=%b exp=0", bus.mem_ready); end
    total++; if (bus.s_addr !== 32'h0001_0004) begin bad++; $display("FAIL ram_rd_s_addr got=%h exp=00010004", bus.s_addr); end
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL ram_rd_c2_ready got=%b exp=1", bus.mem_ready); end
    total++; if (bus.ram_valid !== 1'b0) begin bad++; $display("FAIL ram_rd_c2_valid got=%b exp=0", bus.ram_valid); end
    total++; if (bus.mem_rdata !== 32'h1234_5678) begin bad++; $display("FAIL ram_rd_rdata got=%h exp=12345678", bus.mem_rdata); end
    total++; if (bus.bus_fault !== 1'b0) begin bad++; $display("FAIL ram_rd_fault got=%b exp=0", bus.bus_fault); end
    tick();
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL ram_rd_c3_ready got=%b exp=0", bus.mem_ready); end
  endtask

  task automatic test_io_write();
    bus.io_rdata = 32'h5555_5555;
    drive_req(32'h8000_0010, 32'hA5A5_0F0F, 4'b0011);
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.mem_valid = 1'b0;
      total++; if ({bus.io_valid, bus.mem_ready} !== 2'b10) begin bad++; $display("FAIL io_wr_c%0d valid/ready got=%b exp=10", c, {bus.io_valid, bus.mem_ready}); end
      total++; if ({bus.s_wstrb, bus.s_wdata} !== {4'b0011, 32'hA5A5_0F0F}) begin bad++; $display("FAIL io_wr_c%0d s_bus got=%b/%h exp=0011/a5a50f0f", c, bus.s_wstrb, bus.s_wdata); end
      bus.io_ready = (c == 4);
    end
    tick();
    bus.io_ready = 1'b0;
    total++; if ({bus.io_valid, bus.mem_ready} !== 2'b01) begin bad++; $display("FAIL io_wr_c5 valid/ready got=%b exp=01", {bus.io_valid, bus.mem_ready}); end
    total++; if (bus.mem_rdata !== 32'h1234_5678) begin bad++; $display("FAIL io_wr_rdata_kept got=%h exp=12345678", bus.mem_rdata); end
    tick();
  endtask

  task automatic test_unmapped();
    drive_req(32'h4000_0000, 32'h0, 4'b0000);
    tick();
    bus.mem_valid = 1'b0;
    total++; if ({bus.rom_valid, bus.ram_valid, bus.io_valid} !== 3'b000) begin bad++; $display("FAIL unmap_valids got=%b exp=000", {bus.rom_valid, bus.ram_valid, bus.io_valid}); end
    total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL unmap_ready got=%b exp=1", bus.mem_ready); end
    total++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL unmap_rdata got=%h exp=deadbeef", bus.mem_rdata); end
    total++; if ({bus.bus_fault, bus.err_addr} !== {1'b1, 32'h4000_0000}) begin bad++; $display("FAIL unmap_fault got=%b/%h exp=1/40000000", bus.bus_fault, bus.err_addr); end
    tick();
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL unmap_c2_ready got=%b exp=0", bus.mem_ready); end
  endtask

  task automatic test_timeout();
    drive_req(32'h0000_0100, 32'hFFFF_FFFF, 4'b1111);
    tick();
    bus.mem_valid = 1'b0;
    total++; if ({bus.rom_valid, bus.mem_ready} !== 2'b01) begin bad++; $display("FAIL romwr_valid/ready got=%b exp=01", {bus.rom_valid, bus.mem_ready}); end
    total++; if ({bus.bus_fault, bus.err_addr} !== {1'b1, 32'h0000_0100}) begin bad++; $display("FAIL romwr_fault got=%b/%h exp=1/00000100", bus.bus_fault, bus.err_addr); end
    tick();
    drive_req(32'h0001_0020, 32'h0, 4'b0000);
    for (int c = 1; c <= 16; c++) begin
      tick();
      bus.mem_valid = 1'b0;
      total++; if ({bus.ram_valid, bus.mem_ready} !== 2'b10) begin bad++; $display("FAIL tmo_c%0d valid/ready got=%b exp=10", c, {bus.ram_valid, bus.mem_ready}); end
      bus.io_ready = (c == 5);
    end
    tick();
    bus.io_ready = 1'b0;
    total++; if ({bus.ram_valid, bus.mem_ready} !== 2'b01) begin bad++; $display("FAIL tmo_c17 valid/ready got=%b exp=01", {bus.ram_valid, bus.mem_ready}); end
    total++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tmo_rdata got=%h exp=deadbeef", bus.mem_rdata); end
    total++; if (bus.err_addr !== 32'h0000_0100) begin bad++; $display("FAIL tmo_err_addr got=%h exp=00000100", bus.err_addr); end
    tick();
  endtask

  task automatic test_reset_busy();
    drive_req(32'h0001_0004, 32'h0, 4'b0000);
    tick();
    bus.mem_valid = 1'b0;
    tick();
    total++; if ({bus.ram_valid, bus.bus_fault} !== 2'b11) begin bad++; $display("FAIL rstbusy_pre got=%b exp=11", {bus.ram_valid, bus.bus_fault}); end
    rst = 1'b0;
    tick();
    total++; if ({bus.rom_valid, bus.ram_valid, bus.io_valid, bus.mem_ready} !== 4'b0000) begin bad++; $display("FAIL rstbusy_valids got=%b exp=0000", {bus.rom_valid, bus.ram_valid, bus.io_valid, bus.mem_ready}); end
    total++; if ({bus.bus_fault, bus.err_addr} !== 33'h0) begin bad++; $display("FAIL rstbusy_fault got=%b/%h exp=0/0", bus.bus_fault, bus.err_addr); end
    rst = 1'b1;
    tick();
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rstbusy_post_ready got=%b exp=0", bus.mem_ready); end
    test_ram_read();
  endtask

  task automatic test_back_to_back();
    bus.rom_rdata = 32'hBAD0_BAD0;
    bus.ram_rdata = 32'h1111_1111;
    drive_req(32'h0001_0008, 32'h0, 4'b0000);
    tick();
    bus.mem_valid = 1'b0;
    total++; if ({bus.ram_valid, bus.mem_ready} !== 2'b10) begin bad++; $display("FAIL b2b_c1 got=%b exp=10", {bus.ram_valid, bus.mem_ready}); end
    bus.ram_ready = 1'b1;
    bus.rom_ready = 1'b1;
    tick();
    total++; if ({bus.ram_valid, bus.mem_ready} !== 2'b01) begin bad++; $display("FAIL b2b_c2 got=%b exp=01", {bus.ram_valid, bus.mem_ready}); end
    total++; if (bus.mem_rdata !== 32'h1111_1111) begin bad++; $display("FAIL b2b_rdata1 got=%h exp=11111111", bus.mem_rdata); end
    bus.ram_ready = 1'b0;
    bus.ram_rdata = 32'h2222_2222;
    drive_req(32'h0001_000C, 32'h0, 4'b0000);
    tick();
    bus.mem_valid = 1'b0;
    total++; if ({bus.rom_valid, bus.ram_valid, bus.mem_ready} !== 3'b010) begin bad++; $display("FAIL b2b_c3 got=%b exp=010", {bus.rom_valid, bus.ram_valid, bus.mem_ready}); end
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    bus.rom_ready = 1'b0;
    total++; if ({bus.ram_valid, bus.mem_ready} !== 2'b01) begin bad++; $display("FAIL b2b_c4 got=%b exp=01", {bus.ram_valid, bus.mem_ready}); end
    total++; if (bus.mem_rdata !== 32'h2222_2222) begin bad++; $display("FAIL b2b_rdata2 got=%h exp=22222222", bus.mem_rdata); end
    tick();
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL b2b_c5 got=%b exp=0", bus.mem_ready); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b0000;
    bus.rom_ready = 1'b0;
    bus.ram_ready = 1'b0;
    bus.io_ready  = 1'b0;
    bus.rom_rdata = 32'h0;
    bus.ram_rdata = 32'h0;
    bus.io_rdata  = 32'h0;
    test_reset();
    test_ram_read();
    test_io_write();
    test_unmapped();
    test_reset();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
